register_scoreboard: RTL and testbench
======================================

# register_scoreboard

Per-register write-pending tracker for the ARM pipeline. It decides when an instruction in ID must stall because an older in-flight instruction still owes one of its source registers. It counts writes issued from ID against writes retired in WB, and tracks a load sitting in EX, whose result cannot be forwarded. It sits beside the forwarding unit: forwarding picks the bypass source, and the scoreboard covers the cases forwarding cannot.

## Interface
Parameters:
- NUM_REGS, 16, number of architectural registers tracked (index width 4).
- CNT_W, 2, width of each pending-write counter; maximum in-flight writes per register is 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- forward_en  input  1  1: forwarding enabled; 0: stall on any pending source.
- flush  input  1  branch flush; squashes the ID-stage issue this cycle.
- issue_valid  input  1  instruction in ID requests issue.
- issue_wb_en  input  1  issuing instruction writes a register.
- issue_mem_read  input  1  issuing instruction is a load.
- issue_dest  input  4  destination register.
- issue_src1  input  4  first source register.
- issue_src2  input  4  second source register.
- issue_two_src  input  1  src2 is used.
- wb_valid  input  1  WB stage writes a register this cycle.
- wb_dest  input  4  WB destination.
- stall  output  1  hold IF/ID, insert bubble into EX.
- busy_mask  output  NUM_REGS  bit r = 1 when cnt[r] != 0 (registered state).
- error  output  1  sticky; set on counter underflow.

## Operation
- State:
  - cnt[r] (CNT_W bits) per register.
  - ex_load_valid, ex_load_dest[3:0].
  - error.
- Effective pending for source s: pend(s) = cnt[s] − (wb_valid && wb_dest==s ? 1 : 0). WB in the same cycle resolves the hazard, because the regfile writes on the opposite edge.
- src_hit(s) depends on forward_en:
  - forward_en=0: src_hit(s) = pend(s) != 0.
  - forward_en=1: src_hit(s) = ex_load_valid && ex_load_dest==s.
- stall = issue_valid && !flush && ( src_hit(src1) || (issue_two_src && src_hit(src2)) || (issue_wb_en && cnt[issue_dest]==max && !(wb_valid && wb_dest==issue_dest)) ).
- The last term is the saturation stall. It applies regardless of forward_en.
- accept = issue_valid && !flush && !stall.
- Counter update each edge:
  - cnt[r] += (accept && issue_wb_en && issue_dest==r).
  - cnt[r] −= (wb_valid && wb_dest==r).
  - Both in the same cycle on the same r: value unchanged.
- Underflow: wb_valid to a register with cnt==0 and no same-cycle increment. Counter stays 0 and error is set. error stays set until rst.
- EX-load tracker, on each edge:
  - ex_load_valid <= accept && issue_mem_read && issue_wb_en.
  - ex_load_dest <= issue_dest.
  - A stall or flush therefore loads a bubble (valid=0).
- Reset: all cnt=0, busy_mask=0, ex_load_valid=0, ex_load_dest=0, error=0, stall=0. Reset asserted mid-operation discards all pending state on that edge. rst has priority over every other input.
- flush has priority over stall: when flush=1, stall=0 and nothing is accepted.

## Timing
- stall is combinational from current state and same-cycle inputs. It is valid in the same cycle as issue_valid.
- Accept in cycle N: cnt and busy_mask reflect it from cycle N+1. ex_load_valid is 1 during N+1 only.
- Load-use with forwarding: consumer issued in N+1 stalls exactly one cycle and is accepted in N+2.
- WB in cycle M clears the dependency for a consumer in cycle M. cnt drops on the edge ending M.
- No multi-cycle internal sequencing; zero-latency decision, one-cycle state update.

## Test plan
- Reset: assert rst for 2 cycles with random inputs -> busy_mask=0, stall=0, error=0 on the cycle after release.
- No forwarding RAW:
  - Stimulus: forward_en=0; issue ADD r3 (wb_en) in cycle 0; issue SUB r5,r3 cycle 1.
  - Response: stall=1 in cycles 1..k while cnt[3]=1. wb_valid/wb_dest=3 in cycle 4 gives stall=0 in cycle 4, cnt[3]=0 in cycle 5.
- Load-use:
  - Stimulus: forward_en=1; LDR r2 accepted cycle 0; consumer using r2 as src2 (issue_two_src=1) cycle 1.
  - Response: stall=1 cycle 1, stall=0 cycle 2. Same consumer with issue_two_src=0 and src1!=2: no stall.
- Saturation: accept 3 writes to r7 -> cnt[7]=3. 4th issue to r7 -> stall=1. Same cycle plus wb_dest=7 -> accepted, cnt stays 3.
- Simultaneous/flush:
  - Issue r4 with flush=1 -> cnt[4] unchanged, ex_load_valid=0.
  - Issue r4 plus WB r4 with cnt=1 -> cnt stays 1.
- Underflow: wb_valid wb_dest=9 with cnt[9]=0 -> error=1 next cycle, held until rst; cnt[9] stays 0.

Source files
------------

// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register pending-write tracker for the ID stage.
// Counts writes issued from ID against writes retired in WB, and remembers
// a load sitting in EX whose result cannot be forwarded yet. Raises a
// combinational stall when an issuing instruction would read a register
// that is still owed, or would overflow its destination counter.
module register_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                forward_en,
  input  logic                flush,
  input  logic                issue_valid,
  input  logic                issue_wb_en,
  input  logic                issue_mem_read,
  input  logic [3:0]          issue_dest,
  input  logic [3:0]          issue_src1,
  input  logic [3:0]          issue_src2,
  input  logic                issue_two_src,
  input  logic                wb_valid,
  input  logic [3:0]          wb_dest,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                error
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic                ex_load_valid;
  logic [3:0]          ex_load_dest;

  logic [NUM_REGS-1:0] dec_vec;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] pend_nz;
  logic                src1_hit;
  logic                src2_hit;
  logic                sat_hit;
  logic                accept;

  // Per-register view: retiring writes, still-pending after same-cycle WB, busy bits
  always_comb begin
    dec_vec   = '0;
    pend_nz   = '0;
    busy_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      dec_vec[r]   = wb_valid && (wb_dest == 4'(r));
      pend_nz[r]   = (cnt[r] != CNT_ZERO) && !(dec_vec[r] && (cnt[r] == CNT_ONE));
      busy_mask[r] = (cnt[r] != CNT_ZERO);
    end
  end

  // Hazard decision for the instruction in ID; flush and reset both suppress it
  always_comb begin
    src1_hit = 1'b0;
    src2_hit = 1'b0;
    if (forward_en) begin
      src1_hit = ex_load_valid && (ex_load_dest == issue_src1);
      src2_hit = ex_load_valid && (ex_load_dest == issue_src2);
    end else begin
      src1_hit = pend_nz[issue_src1];
      src2_hit = pend_nz[issue_src2];
    end
    sat_hit = issue_wb_en && (cnt[issue_dest] == CNT_MAX) &&
              !(wb_valid && (wb_dest == issue_dest));
    stall   = !rst && issue_valid && !flush &&
              (src1_hit || (issue_two_src && src2_hit) || sat_hit);
    accept  = issue_valid && !flush && !stall;
  end

  // Which counter the accepted instruction claims this cycle
  always_comb begin
    inc_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = accept && issue_wb_en && (issue_dest == 4'(r));
    end
  end

  // Pending-write counters: issue increments, WB decrements, both cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= CNT_ZERO;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != CNT_ZERO)) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  // Sticky flag for a WB retiring a write that was never issued
  always_ff @(posedge clk) begin
    if (rst) begin
      error <= 1'b0;
    end else if (|(dec_vec & ~inc_vec & ~busy_mask)) begin
      error <= 1'b1;
    end
  end

  // Track a load moving into EX; stalls and flushes become bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_load_valid <= 1'b0;
      ex_load_dest  <= 4'd0;
    end else begin
      ex_load_valid <= accept && issue_mem_read && issue_wb_en;
      ex_load_dest  <= issue_dest;
    end
  end

endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard: table-driven directed test for register_scoreboard.
module tb_register_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        forward_en;
  logic        flush;
  logic        issue_valid;
  logic        issue_wb_en;
  logic        issue_mem_read;
  logic [3:0]  issue_dest;
  logic [3:0]  issue_src1;
  logic [3:0]  issue_src2;
  logic        issue_two_src;
  logic        wb_valid;
  logic [3:0]  wb_dest;
  logic        stall;
  logic [15:0] busy_mask;
  logic        error;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        fwd;
    logic        flush;
    logic        iv;
    logic        wbe;
    logic        mr;
    logic [3:0]  dest;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        two;
    logic        wbv;
    logic [3:0]  wbd;
    logic        exp_stall;
    logic [15:0] exp_busy;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  register_scoreboard #(.NUM_REGS(16), .CNT_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .forward_en     (forward_en),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_wb_en    (issue_wb_en),
    .issue_mem_read (issue_mem_read),
    .issue_dest     (issue_dest),
    .issue_src1     (issue_src1),
    .issue_src2     (issue_src2),
    .issue_two_src  (issue_two_src),
    .wb_valid       (wb_valid),
    .wb_dest        (wb_dest),
    .stall          (stall),
    .busy_mask      (busy_mask),
    .error          (error)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  function automatic void add(input int r, input int fwd, input int fl, input int iv,
                              input int wbe, input int mr, input int dest, input int s1,
                              input int s2, input int two, input int wbv, input int wbd,
                              input int es, input int eb, input int ee);
    vec_t v;
    v.rst = (r != 0);      v.fwd = (fwd != 0);   v.flush = (fl != 0);
    v.iv = (iv != 0);      v.wbe = (wbe != 0);   v.mr = (mr != 0);
    v.dest = 4'(dest);     v.s1 = 4'(s1);        v.s2 = 4'(s2);
    v.two = (two != 0);    v.wbv = (wbv != 0);   v.wbd = 4'(wbd);
    v.exp_stall = (es != 0);
    v.exp_busy = 16'(eb);
    v.exp_err = (ee != 0);
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst            = v.rst;
    forward_en     = v.fwd;
    flush          = v.flush;
    issue_valid    = v.iv;
    issue_wb_en    = v.wbe;
    issue_mem_read = v.mr;
    issue_dest     = v.dest;
    issue_src1     = v.s1;
    issue_src2     = v.s2;
    issue_two_src  = v.two;
    wb_valid       = v.wbv;
    wb_dest        = v.wbd;
  endtask

  task automatic applyRandom(input logic r);
    logic [22:0] bits;
    bits = 23'($urandom);
    rst = r;
    {forward_en, flush, issue_valid, issue_wb_en, issue_mem_read, issue_dest,
     issue_src1, issue_src2, issue_two_src, wb_valid, wb_dest} = bits;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s vec=%0d got=%h expected=%h", name, idx, actual, expected);
    end
  endtask

  initial begin
    // columns: rst fwd flush iv wbe mr dest s1 s2 two wbv wbd | stall busy err
    add(1,0,0,0,0,0, 0,0,0,0, 0,0,  0,'h0000,0);
    // no-forwarding RAW on r3, resolved by WB in the same cycle
    add(0,0,0,1,1,0, 3,0,0,0, 0,0,  0,'h0008,0);
    add(0,0,0,1,1,0, 5,3,0,0, 0,0,  1,'h0008,0);
    add(0,0,0,1,1,0, 5,3,0,0, 0,0,  1,'h0008,0);
    add(0,0,0,1,1,0, 5,3,0,0, 1,3,  0,'h0020,0);
    add(0,0,0,0,0,0, 0,0,0,0, 1,5,  0,'h0000,0);
    // load-use on r2 with forwarding
    add(0,1,0,1,1,1, 2,0,0,0, 0,0,  0,'h0004,0);
    add(0,1,0,1,1,0, 6,1,2,1, 0,0,  1,'h0004,0);
    add(0,1,0,1,1,0, 6,1,2,1, 0,0,  0,'h0044,0);
    add(0,1,0,1,1,1, 2,0,0,0, 0,0,  0,'h0044,0);
    add(0,1,0,1,1,0, 8,1,2,0, 0,0,  0,'h0144,0);
    add(0,1,0,1,0,0, 0,2,0,0, 0,0,  0,'h0144,0);
    add(0,0,0,1,0,0, 0,2,0,0, 0,0,  1,'h0144,0);
    add(0,0,0,0,0,0, 0,0,0,0, 1,2,  0,'h0144,0);
    add(0,0,0,0,0,0, 0,0,0,0, 1,2,  0,'h0140,0);
    add(0,0,0,0,0,0, 0,0,0,0, 1,6,  0,'h0100,0);
    add(0,0,0,0,0,0, 0,0,0,0, 1,8,  0,'h0000,0);
    // saturation on r7
    add(0,1,0,1,1,0, 7,0,0,0, 0,0,  0,'h0080,0);
    add(0,1,0,1,1,0, 7,0,0,0, 0,0,  0,'h0080,0);
    add(0,1,0,1,1,0, 7,0,0,0, 0,0,  0,'h0080,0);
    add(0,1,0,1,1,0, 7,0,0,0, 0,0,  1,'h0080,0);
    add(0,1,0,1,1,0, 7,0,0,0, 1,7,  0,'h0080,0);
    add(0,0,0,1,1,0, 7,0,0,0, 0,0,  1,'h0080,0);
    add(0,0,0,0,0,0, 0,0,0,0, 1,7,  0,'h0080,0);
    add(0,0,0,0,0,0, 0,0,0,0, 1,7,  0,'h0080,0);
    add(0,0,0,0,0,0, 0,0,0,0, 1,7,  0,'h0000,0);
    // flush squashes a load and overrides a pending stall
    add(0,1,1,1,1,1, 4,0,0,0, 0,0,  0,'h0000,0);
    add(0,1,0,1,1,0, 5,4,0,0, 0,0,  0,'h0020,0);
    add(0,0,1,1,0,0, 0,5,0,0, 0,0,  0,'h0020,0);
    add(0,0,0,0,0,0, 0,0,0,0, 1,5,  0,'h0000,0);
    // simultaneous issue and WB on r4
    add(0,1,0,1,1,0, 4,0,0,0, 0,0,  0,'h0010,0);
    add(0,1,0,1,1,0, 4,0,0,0, 1,4,  0,'h0010,0);
    add(0,0,0,0,0,0, 0,0,0,0, 1,4,  0,'h0000,0);
    // underflow on r9, sticky until reset
    add(0,0,0,0,0,0, 0,0,0,0, 1,9,  0,'h0000,1);
    add(0,0,0,0,0,0, 0,0,0,0, 0,0,  0,'h0000,1);
    add(0,1,0,1,1,0, 9,0,0,0, 0,0,  0,'h0200,1);
    add(0,0,0,0,0,0, 0,0,0,0, 1,9,  0,'h0000,1);
    add(1,0,0,0,0,0, 0,0,0,0, 0,0,  0,'h0000,0);
    // reset mid-operation discards pending state
    add(0,1,0,1,1,0, 1,0,0,0, 0,0,  0,'h0002,0);
    add(1,1,0,1,1,0, 1,0,0,0, 0,0,  0,'h0000,0);
    add(0,0,0,0,0,0, 0,0,0,0, 0,0,  0,'h0000,0);

    // reset held for two cycles under random inputs
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      applyRandom(1'b1);
      #1;
      checkOutput("rst_stall", c, 16'(stall), 16'h0);
      @(posedge clk);
      #1;
      checkOutput("rst_busy", c, busy_mask, 16'h0);
      checkOutput("rst_error", c, 16'(error), 16'h0);
    end
    @(negedge clk);
    applyRandom(1'b0);
    #1;
    checkOutput("post_rst_stall", 0, 16'(stall), 16'h0);
    checkOutput("post_rst_busy", 0, busy_mask, 16'h0);
    checkOutput("post_rst_error", 0, 16'(error), 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput("stall", i, 16'(stall), 16'(vecs[i].exp_stall));
      @(posedge clk);
      #1;
      checkOutput("busy_mask", i, busy_mask, vecs[i].exp_busy);
      checkOutput("error", i, 16'(error), 16'(vecs[i].exp_err));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
